// File: rtl/multdiv_unit_if.sv
// Result/operand bundle between the execute stage and the iterative mult/div unit.
// Signal names match the pipeline wiring so hazard logic can tap busy directly.
interface multdiv_unit_if #(
  parameter int WIDTH = 32,
  parameter int TAGW  = 5
);
  logic [WIDTH-1:0] data_operandA;
  logic [WIDTH-1:0] data_operandB;
  logic             ctrl_mult;
  logic             ctrl_div;
  logic [TAGW-1:0]  rd_in;
  logic [WIDTH-1:0] data_result;
  logic             data_exception;
  logic             data_resultRDY;
  logic             busy;
  logic [TAGW-1:0]  rd_out;

  modport master (
    output data_operandA, data_operandB, ctrl_mult, ctrl_div, rd_in,
    input  data_result, data_exception, data_resultRDY, busy, rd_out
  );

  modport slave (
    input  data_operandA, data_operandB, ctrl_mult, ctrl_div, rd_in,
    output data_result, data_exception, data_resultRDY, busy, rd_out
  );
endinterface

// File: rtl/multdiv_unit.sv
// Iterative signed multiply / divide: one radix-2 step per clock on magnitudes,
// sign fix-up on the last step, one-cycle result strobe with the latched tag.
//   state | meaning
//   IDLE  | waiting for ctrl_mult / ctrl_div
//   RUN   | iterating, busy high
//   DONE  | data_resultRDY strobe cycle
module multdiv_unit #(
  parameter int WIDTH = 32,
  parameter int TAGW  = 5
) (
  input  logic           clock,
  input  logic           reset,
  multdiv_unit_if.slave  bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             r_state;
  logic [CW-1:0]      r_count;
  logic               r_is_div;
  logic               r_neg;
  logic               r_dbz;
  logic [WIDTH-1:0]   r_op_b;
  logic [2*WIDTH-1:0] r_acc;

  logic [WIDTH-1:0]   r_result;
  logic               r_exception;
  logic               r_rdy;
  logic               r_busy;
  logic [TAGW-1:0]    r_rd;

  logic               w_start;
  logic               w_start_div;
  logic [WIDTH-1:0]   w_mag_a;
  logic [WIDTH-1:0]   w_mag_b;
  logic [WIDTH:0]     w_add;
  logic [2*WIDTH-1:0] w_mul_next;
  logic [WIDTH:0]     w_trial;
  logic [2*WIDTH-1:0] w_div_next;
  logic [2*WIDTH-1:0] w_acc_next;
  logic [2*WIDTH-1:0] w_prod_s;
  logic [WIDTH-1:0]   w_quot_s;
  logic [WIDTH-1:0]   w_fin_result;
  logic               w_fin_exc;

  assign w_start     = bus.ctrl_mult | bus.ctrl_div;
  assign w_start_div = bus.ctrl_div & ~bus.ctrl_mult;
  assign w_mag_a = bus.data_operandA[WIDTH-1] ? -bus.data_operandA : bus.data_operandA;
  assign w_mag_b = bus.data_operandB[WIDTH-1] ? -bus.data_operandB : bus.data_operandB;

  // Multiply keeps the multiplier in the low half and shifts the partial product in from the top;
  // divide keeps remainder:quotient and shifts left, restoring on a negative trial.
  always_comb begin
    w_add        = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_op_b} : '0);
    w_mul_next   = {w_add, r_acc[WIDTH-1:1]};
    w_trial      = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_op_b};
    w_div_next   = w_trial[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                  : {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    w_acc_next   = r_is_div ? w_div_next : w_mul_next;
    w_prod_s     = r_neg ? -w_acc_next : w_acc_next;
    w_quot_s     = r_neg ? -w_acc_next[WIDTH-1:0] : w_acc_next[WIDTH-1:0];
    w_fin_result = '0;
    w_fin_exc    = 1'b0;
    if (!r_is_div) begin
      w_fin_result = w_prod_s[WIDTH-1:0];
      w_fin_exc    = !((&w_prod_s[2*WIDTH-1:WIDTH-1]) || (~|w_prod_s[2*WIDTH-1:WIDTH-1]));
    end else if (r_dbz) begin
      w_fin_result = '0;
      w_fin_exc    = 1'b1;
    end else begin
      w_fin_result = w_quot_s;
      // only a positive quotient of 2^(WIDTH-1) (MIN / -1) can overflow
      w_fin_exc    = !r_neg && w_acc_next[WIDTH-1];
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= IDLE;
      r_count     <= '0;
      r_is_div    <= 1'b0;
      r_neg       <= 1'b0;
      r_dbz       <= 1'b0;
      r_op_b      <= '0;
      r_acc       <= '0;
      r_result    <= '0;
      r_exception <= 1'b0;
      r_rdy       <= 1'b0;
      r_busy      <= 1'b0;
      r_rd        <= '0;
    end else if (w_start) begin
      r_state  <= RUN;
      r_count  <= '0;
      r_is_div <= w_start_div;
      r_neg    <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
      r_dbz    <= w_start_div && (bus.data_operandB == '0);
      r_op_b   <= w_start_div ? w_mag_b : w_mag_a;
      r_acc    <= {{WIDTH{1'b0}}, (w_start_div ? w_mag_a : w_mag_b)};
      r_rdy    <= 1'b0;
      r_busy   <= 1'b1;
      r_rd     <= bus.rd_in;
    end else begin
      case (r_state)
        RUN: begin
          r_acc   <= w_acc_next;
          r_count <= r_count + 1'b1;
          if (r_count == CW'(WIDTH - 1)) begin
            r_result    <= w_fin_result;
            r_exception <= w_fin_exc;
            r_rdy       <= 1'b1;
            r_busy      <= 1'b0;
            r_state     <= DONE;
          end
        end
        DONE: begin
          r_rdy   <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.data_result    = r_result;
  assign bus.data_exception = r_exception;
  assign bus.data_resultRDY = r_rdy;
  assign bus.busy           = r_busy;
  assign bus.rd_out         = r_rd;
endmodule

// File: tb/tb_multdiv_unit.sv
// Directed bench for multdiv_unit: latency, arithmetic, exceptions, restart and reset abort.
module tb_multdiv_unit;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  multdiv_unit_if #(.WIDTH(32), .TAGW(5)) bus ();

  multdiv_unit #(.WIDTH(32), .TAGW(5)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Pulses the start line(s) for one edge, then counts edges until the strobe.
  task automatic do_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output int lat, output int busy_lo);
    @(negedge clock);
    bus.ctrl_mult = m; bus.ctrl_div = d;
    bus.data_operandA = a; bus.data_operandB = b; bus.rd_in = rd;
    @(negedge clock);
    bus.ctrl_mult = 1'b0; bus.ctrl_div = 1'b0;
    lat = 0; busy_lo = 0;
    while (!bus.data_resultRDY && lat < 100) begin
      if (!bus.busy) busy_lo++;
      @(negedge clock);
      lat++;
    end
  endtask

  task automatic test_reset();
    @(negedge clock);
    n_checks++;
    if (bus.data_result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", bus.data_result); end
    n_checks++;
    if ({bus.data_exception, bus.data_resultRDY, bus.busy} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 000", {bus.data_exception, bus.data_resultRDY, bus.busy});
    end
    n_checks++;
    if (bus.rd_out !== 5'd0) begin n_fail++; $display("FAIL reset_rd: got %0d expected 0", bus.rd_out); end
    reset = 1'b0;
  endtask

  task automatic test_mult_basic();
    int lat, blo;
    do_op(1'b1, 1'b0, 32'd6, 32'd7, 5'd3, lat, blo);
    n_checks++;
    if (lat !== 32) begin n_fail++; $display("FAIL mult_latency: got %0d expected 32", lat); end
    n_checks++;
    if (blo !== 0) begin n_fail++; $display("FAIL mult_busy: low %0d cycles expected 0", blo); end
    n_checks++;
    if (bus.data_result !== 32'd42 || bus.data_exception !== 1'b0 || bus.rd_out !== 5'd3) begin
      n_fail++; $display("FAIL mult_6x7: got %h/%b/%0d expected 0000002a/0/3", bus.data_result, bus.data_exception, bus.rd_out);
    end
    n_checks++;
    if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mult_busy_done: got %b expected 0", bus.busy); end
    @(negedge clock);
    n_checks++;
    if (bus.data_resultRDY !== 1'b0) begin n_fail++; $display("FAIL mult_strobe_width: got %b expected 0", bus.data_resultRDY); end
    repeat (3) @(negedge clock);
    n_checks++;
    if (bus.data_result !== 32'd42 || bus.rd_out !== 5'd3 || bus.data_resultRDY !== 1'b0) begin
      n_fail++; $display("FAIL mult_hold: got %h/%0d/%b expected 0000002a/3/0", bus.data_result, bus.rd_out, bus.data_resultRDY);
    end
  endtask

  task automatic test_mult_signed();
    logic [31:0] va [3] = '{32'hFFFFFFFD, 32'h00010000, 32'h80000000};
    logic [31:0] vb [3] = '{32'd5,        32'h00010000, 32'd1};
    logic [31:0] vr [3] = '{32'hFFFFFFF1, 32'h00000000, 32'h80000000};
    logic        ve [3] = '{1'b0,         1'b1,         1'b0};
    int lat, blo;
    for (int i = 0; i < 3; i++) begin
      do_op(1'b1, 1'b0, va[i], vb[i], 5'(i + 10), lat, blo);
      n_checks++;
      if (lat !== 32 || bus.data_result !== vr[i] || bus.data_exception !== ve[i]) begin
        n_fail++;
        $display("FAIL mult_signed[%0d]: got lat %0d %h/%b expected lat 32 %h/%b", i, lat, bus.data_result, bus.data_exception, vr[i], ve[i]);
      end
    end
  endtask

  task automatic test_div();
    logic [31:0] va [3] = '{32'd100,      32'hFFFFFFF9, 32'd7};
    logic [31:0] vb [3] = '{32'hFFFFFFF9, 32'd2,        32'd9};
    logic [31:0] vr [3] = '{32'hFFFFFFF2, 32'hFFFFFFFD, 32'd0};
    int lat, blo;
    for (int i = 0; i < 3; i++) begin
      do_op(1'b0, 1'b1, va[i], vb[i], 5'(i + 20), lat, blo);
      n_checks++;
      if (lat !== 32 || bus.data_result !== vr[i] || bus.data_exception !== 1'b0 || bus.rd_out !== 5'(i + 20)) begin
        n_fail++;
        $display("FAIL div[%0d]: got lat %0d %h/%b rd %0d expected lat 32 %h/0 rd %0d", i, lat, bus.data_result, bus.data_exception, bus.rd_out, vr[i], i + 20);
      end
    end
  endtask

  task automatic test_div_exc();
    int lat, blo;
    do_op(1'b0, 1'b1, 32'd5, 32'd0, 5'd1, lat, blo);
    n_checks++;
    if (lat !== 32 || bus.data_result !== 32'd0 || bus.data_exception !== 1'b1) begin
      n_fail++; $display("FAIL div_by_zero: got lat %0d %h/%b expected lat 32 00000000/1", lat, bus.data_result, bus.data_exception);
    end
    do_op(1'b0, 1'b1, 32'h80000000, 32'hFFFFFFFF, 5'd2, lat, blo);
    n_checks++;
    if (lat !== 32 || bus.data_result !== 32'h80000000 || bus.data_exception !== 1'b1) begin
      n_fail++; $display("FAIL div_min_neg1: got lat %0d %h/%b expected lat 32 80000000/1", lat, bus.data_result, bus.data_exception);
    end
  endtask

  task automatic test_restart();
    int strobes = 0, at = 0;
    logic [31:0] res = '0;
    logic [4:0]  rd = '0;
    @(negedge clock);
    bus.ctrl_mult = 1'b1; bus.data_operandA = 32'd6; bus.data_operandB = 32'd7; bus.rd_in = 5'd3;
    @(negedge clock);
    bus.ctrl_mult = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (bus.data_resultRDY) strobes++;
      @(negedge clock);
    end
    bus.ctrl_div = 1'b1; bus.data_operandA = 32'd20; bus.data_operandB = 32'd4; bus.rd_in = 5'd9;
    @(negedge clock);
    bus.ctrl_div = 1'b0;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clock);
      if (bus.data_resultRDY) begin
        strobes++; at = i; res = bus.data_result; rd = bus.rd_out;
      end
    end
    n_checks++;
    if (strobes !== 1) begin n_fail++; $display("FAIL restart_strobes: got %0d expected 1", strobes); end
    n_checks++;
    if (at !== 32 || res !== 32'd5 || rd !== 5'd9) begin
      n_fail++; $display("FAIL restart_result: got at %0d %h rd %0d expected at 32 00000005 rd 9", at, res, rd);
    end
  endtask

  task automatic test_reset_mid();
    int strobes = 0, lat, blo;
    @(negedge clock);
    bus.ctrl_mult = 1'b1; bus.data_operandA = 32'd9; bus.data_operandB = 32'd9; bus.rd_in = 5'd7;
    @(negedge clock);
    bus.ctrl_mult = 1'b0;
    repeat (14) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    n_checks++;
    if ({bus.data_exception, bus.data_resultRDY, bus.busy} !== 3'b000 || bus.data_result !== 32'h0 || bus.rd_out !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got %h exc %b rdy %b busy %b rd %0d expected all 0", bus.data_result, bus.data_exception, bus.data_resultRDY, bus.busy, bus.rd_out);
    end
    for (int i = 0; i < 50; i++) begin
      @(negedge clock);
      if (bus.data_resultRDY || bus.busy) strobes++;
    end
    n_checks++;
    if (strobes !== 0) begin n_fail++; $display("FAIL reset_mid_no_strobe: got %0d active cycles expected 0", strobes); end
    do_op(1'b1, 1'b1, 32'd4, 32'd3, 5'd4, lat, blo);
    n_checks++;
    if (lat !== 32 || bus.data_result !== 32'd12 || bus.data_exception !== 1'b0) begin
      n_fail++; $display("FAIL both_ctrl_mult: got lat %0d %h/%b expected lat 32 0000000c/0", lat, bus.data_result, bus.data_exception);
    end
  endtask

  initial begin
    bus.ctrl_mult = 1'b0; bus.ctrl_div = 1'b0;
    bus.data_operandA = '0; bus.data_operandB = '0; bus.rd_in = '0;
    repeat (2) @(posedge clock);
    test_reset();
    test_mult_basic();
    test_mult_signed();
    test_div();
    test_div_exc();
    test_restart();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/multdiv_unit.md
Name: multdiv_unit

Overview:
- Iterative signed 32-bit multiplier/divider in the execute stage.
- Runs alongside the ALU and feeds its result to writeback once done.
- Mult/div instructions entering X/M are bubbled, so this unit alone carries the result and destination tag.
- Asserts busy so the hazard/stall logic can hold fetch/decode and block dependent instructions.

Parameters:
WIDTH, 32, operand/result width; iteration count equals WIDTH.
TAGW, 5, destination-register tag width.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
data_operandA  input  WIDTH  multiplicand / dividend (two's complement).
data_operandB  input  WIDTH  multiplier / divisor (two's complement).
ctrl_mult  input  1  start multiply; sampled each edge.
ctrl_div  input  1  start divide; sampled each edge.
rd_in  input  TAGW  destination register of the starting instruction.
data_result  output  WIDTH  product low word or quotient.
data_exception  output  1  overflow / divide-by-zero flag, qualified by data_resultRDY.
data_resultRDY  output  1  one-cycle result-valid strobe.
busy  output  1  operation in flight; drives pipeline stall.
rd_out  output  TAGW  tag latched at start; valid with data_resultRDY.

Behaviour:
- Reset (synchronous, wins over everything):
  - state IDLE, count 0.
  - All outputs 0: data_result, data_exception, data_resultRDY, busy, rd_out.
- States:
  - IDLE: wait for start.
  - RUN: iterating.
  - DONE: result strobe cycle; falls back to IDLE.
- Start edge E0 (ctrl_mult or ctrl_div high, in any state):
  - Latch operand magnitudes, result sign, op type and rd_in.
  - Flag divide-by-zero.
  - count <= 0, state RUN; after E0, busy=1 and data_resultRDY=0.
  - Both ctrl lines high: treated as multiply.
- RUN, edges E1..E32:
  - One iteration per edge: radix-2 shift-add for mult, restoring shift-subtract for div, on unsigned magnitudes; count increments.
  - At E32: apply sign correction, register data_result and data_exception, data_resultRDY <= 1, busy <= 0, state DONE.
- Latency: result visible in the cycle following the 32nd edge after the start edge; independent of operand values, including divide-by-zero.
- DONE:
  - Next edge clears data_resultRDY, state IDLE.
  - data_result, data_exception and rd_out hold until the next start edge or reset.
- Start while RUN (restart): current operation is aborted with no strobe; the new one begins at that edge with full 32-edge latency.
- Start in DONE cycle: accepted as a normal E0; data_resultRDY drops.
- Multiply arithmetic:
  - Full 2*WIDTH signed product.
  - data_result = low WIDTH bits.
  - data_exception = 1 iff the upper WIDTH+1 bits are not all equal, i.e. the product does not fit in signed WIDTH.
- Divide arithmetic:
  - Quotient truncated toward zero, sign = signA xor signB; remainder discarded.
  - Divisor 0: data_result 0, data_exception 1.
  - 0x80000000 / -1: data_result 0x80000000, data_exception 1.
  - All other cases: data_exception 0.
- Reset mid-operation: aborts; no strobe is ever produced for the aborted op.
- busy is a registered output, with no combinational path from ctrl inputs. The stall unit treats the start cycle itself as stalled via decode of the instruction.

Test Plan:
- Multiply 6 x 7, rd_in=3, single-cycle ctrl_mult:
  - busy=1 for 32 cycles.
  - Then data_resultRDY=1 for exactly 1 cycle with result 42, exception 0, rd_out 3.
  - Outputs hold afterwards.
- Multiply signed and overflow cases:
  - -3 x 5 -> 0xFFFFFFF1, exception 0.
  - 0x00010000 x 0x00010000 -> 0x00000000, exception 1.
  - 0x80000000 x 1 -> 0x80000000, exception 0.
- Divide:
  - 100 / -7 -> 0xFFFFFFF2 (-14), exception 0.
  - -7 / 2 -> 0xFFFFFFFD (-3).
  - 7 / 9 -> 0.
- Divide exceptions:
  - 5 / 0 -> result 0, exception 1, still 32-edge latency.
  - 0x80000000 / -1 -> 0x80000000, exception 1.
- Restart: start mult 6x7 (rd 3); 10 edges later start div 20/4 (rd 9):
  - No strobe for the mult.
  - Single strobe 32 edges after the div start with result 5, rd_out 9.
- Reset and priority:
  - Assert reset at edge 15 of an op: all outputs 0 next cycle; no strobe ever appears.
  - Then pulse ctrl_mult and ctrl_div together with operands 4, 3 -> result 12 (multiply).
